seq_calc: RTL and testbench



---
 rtl/seq_calc_pkg.sv | 16 +
 rtl/seq_calc_divu.sv | 78 +++++++
 rtl/seq_calc.sv | 154 +++++++++++++++
 tb/tb_seq_calc.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/seq_calc_pkg.sv
// seq_calc_pkg: shared op encodings and FSM state type for seq_calc.
// No ports; imported by seq_calc and seq_calc_divu.
package seq_calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_calc_divu.sv
// seq_calc_divu: unsigned WIDTH-bit iterative restoring divider, one bit/cycle.
// Ports: clk, rst (sync, high), start, dividend, divisor -> busy, done, quotient, remainder.
module seq_calc_divu
    import seq_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_in;
    logic [WIDTH-1:0] quo_in;
    logic [WIDTH-1:0] dvs_in;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;

    // The first step is taken on the start edge itself, so the
    // quotient is final WIDTH-1 edges later and done pulses then.
    always_comb begin
        rem_in = start ? '0 : remainder;
        quo_in = start ? dividend : quotient;
        dvs_in = start ? divisor : dvs_q;
        part   = {rem_in, quo_in[WIDTH-1]};
        diff   = part - {1'b0, dvs_in};
        // rem < divisor keeps part - divisor below 2^WIDTH, so the
        // top bit of diff is a pure borrow flag.
        if (!diff[WIDTH]) begin
            rem_nx = diff[WIDTH-1:0];
            quo_nx = {quo_in[WIDTH-2:0], 1'b1};
        end else begin
            rem_nx = part[WIDTH-1:0];
            quo_nx = {quo_in[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quotient  <= quo_nx;
                remainder <= rem_nx;
                dvs_q     <= divisor;
                cnt       <= '0;
                busy      <= 1'b1;
            end else if (busy) begin
                quotient  <= quo_nx;
                remainder <= rem_nx;
                cnt       <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 2)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/seq_calc.sv
// seq_calc: clocked signed add/sub/mul/div with valid/ready on both sides.
// Ports: clk, rst, in_valid/in_ready, a, b, op -> out_valid/out_ready,
// result, div_by_zero; rem only when SEQ_CALC_REM_EN is defined.
module seq_calc
    import seq_calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    input  logic [1:0]                op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [2*WIDTH-1:0] result,
`ifdef SEQ_CALC_REM_EN
    output logic signed [WIDTH-1:0]   rem,
`endif
    output logic                      div_by_zero
);

    state_t state;

    logic                      accept;
    logic                      div_start;
    logic                      div_busy;
    logic                      div_done;
    logic [WIDTH-1:0]          div_q;
    logic [WIDTH-1:0]          div_r;
    logic [WIDTH-1:0]          a_abs;
    logic [WIDTH-1:0]          b_abs;
    logic signed [2*WIDTH-1:0] a_ext;
    logic signed [2*WIDTH-1:0] b_ext;
    logic signed [2*WIDTH-1:0] q_ext;
    logic signed [2*WIDTH-1:0] q_res;
    logic                      sign_q;
    logic                      unused_div;

    assign in_ready  = (state == ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign div_start = accept && (op == OP_DIV) && (b != '0);

    assign a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_ext = {{WIDTH{b[WIDTH-1]}}, b};

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exact as unsigned.
    assign a_abs = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign b_abs = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    // Quotient magnitude is unsigned, so zero-extend before negating.
    assign q_ext = {{WIDTH{1'b0}}, div_q};
    assign q_res = sign_q ? -q_ext : q_ext;

`ifdef SEQ_CALC_REM_EN
    logic                    sign_r;
    logic signed [WIDTH-1:0] r_res;

    assign r_res      = sign_r ? -$signed(div_r) : $signed(div_r);
    assign unused_div = div_busy;
`else
    assign unused_div = div_busy ^ (^div_r);
`endif

    seq_calc_divu #(
        .WIDTH(WIDTH)
    ) u_divu (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (a_abs),
        .divisor  (b_abs),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q),
        .remainder(div_r)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            out_valid   <= 1'b0;
            result      <= '0;
            div_by_zero <= 1'b0;
            sign_q      <= 1'b0;
`ifdef SEQ_CALC_REM_EN
            sign_r      <= 1'b0;
            rem         <= '0;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        div_by_zero <= 1'b0;
`ifdef SEQ_CALC_REM_EN
                        rem         <= '0;
`endif
                        unique case (op)
                            OP_ADD: begin
                                result    <= a_ext + b_ext;
                                out_valid <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_SUB: begin
                                result    <= a_ext - b_ext;
                                out_valid <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_MUL: begin
                                result    <= a_ext * b_ext;
                                out_valid <= 1'b1;
                                state     <= ST_DONE;
                            end
                            OP_DIV: begin
                                if (b == '0) begin
                                    result      <= '0;
                                    div_by_zero <= 1'b1;
                                    out_valid   <= 1'b1;
                                    state       <= ST_DONE;
                                end else begin
                                    sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
`ifdef SEQ_CALC_REM_EN
                                    sign_r <= a[WIDTH-1];
`endif
                                    state  <= ST_DIV;
                                end
                            end
                        endcase
                    end
                end
                ST_DIV: begin
                    if (div_done) begin
                        result    <= q_res;
`ifdef SEQ_CALC_REM_EN
                        rem       <= r_res;
`endif
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_calc.sv
// tb_seq_calc: directed plus random checks of seq_calc (WIDTH=8)
// against an integer-arithmetic reference model.
module tb_seq_calc;

    localparam int W = 8;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic signed [W-1:0]   a = '0;
    logic signed [W-1:0]   b = '0;
    logic [1:0]            op = 2'b00;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic signed [2*W-1:0] result;
    logic                  div_by_zero;
`ifdef SEQ_CALC_REM_EN
    logic signed [W-1:0]   rem;
`endif

    int total = 0;
    int bad   = 0;

    seq_calc #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
`ifdef SEQ_CALC_REM_EN
        .rem        (rem),
`endif
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One full transaction: model, issue, latency, result, optional
    // stall with ignored in_valid pulses, then handshake.
    task automatic run_op(input int ai, input int bi, input int opi,
                          input int hold, input bit pulses);
        longint exp_r;
        longint exp_rem;
        int     exp_lat;
        bit     exp_dbz;
        int     lat;
        bit     rdy_low;
        exp_rem = 0;
        exp_dbz = 1'b0;
        exp_lat = 1;
        case (opi)
            0: exp_r = ai + bi;
            1: exp_r = ai - bi;
            2: exp_r = ai * bi;
            default: begin
                if (bi == 0) begin
                    exp_r   = 0;
                    exp_dbz = 1'b1;
                end else begin
                    exp_r   = ai / bi;
                    exp_rem = ai % bi;
                    exp_lat = W + 1;
                end
            end
        endcase
        lat = 0;
        while (!in_ready && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_before", longint'(in_ready), 1);
        out_ready = (hold == 0);
        in_valid  = 1'b1;
        a         = W'(ai);
        b         = W'(bi);
        op        = 2'(opi);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat     = 0;
        rdy_low = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) rdy_low = 1'b0;
        end while (!out_valid && lat < 40);
        check("latency", lat, exp_lat);
        check("in_ready_busy", longint'(rdy_low), 1);
        check("result", result, exp_r);
        check("div_by_zero", longint'(div_by_zero), longint'(exp_dbz));
`ifdef SEQ_CALC_REM_EN
        check("rem", rem, exp_rem);
`endif
        for (int i = 0; i < hold; i++) begin
            if (pulses) begin
                in_valid = 1'b1;
                a        = W'($urandom);
                b        = W'($urandom);
                op       = 2'($urandom);
            end
            @(negedge clk);
            check("hold_valid", longint'(out_valid), 1);
            check("hold_result", result, exp_r);
            check("hold_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_valid", longint'(out_valid), 0);
        check("post_in_ready", longint'(in_ready), 1);
    endtask

    initial begin
        // reset values
        repeat (2) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_result", result, 0);
        check("rst_dbz", longint'(div_by_zero), 0);
        check("rst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // add / sub extremes
        run_op(127, 127, 0, 0, 1'b0);
        run_op(-128, 127, 1, 0, 1'b0);
        // mul corners
        run_op(-128, -128, 2, 0, 1'b0);
        run_op(-128, 127, 2, 0, 1'b0);
        // div with sign and overflow-free corner
        run_op(-7, 2, 3, 0, 1'b0);
        run_op(-128, -1, 3, 0, 1'b0);
        // div by zero then flag clears
        run_op(5, 0, 3, 0, 1'b0);
        run_op(3, 4, 0, 0, 1'b0);
        // sink stall with ignored requests
        run_op(-50, 9, 2, 5, 1'b1);
        run_op(77, -5, 3, 5, 1'b1);

        // reset mid-division
        in_valid = 1'b1;
        a        = W'(100);
        b        = W'(7);
        op       = 2'b11;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", longint'(out_valid), 0);
        check("midrst_result", result, 0);
        check("midrst_in_ready", longint'(in_ready), 1);
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("midrst_no_stale", longint'(out_valid), 0);
        run_op(100, 7, 3, 0, 1'b0);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            int ra;
            int rb;
            ra = int'($urandom_range(0, 255)) - 128;
            rb = ($urandom_range(0, 7) == 0) ? 0
                 : int'($urandom_range(0, 255)) - 128;
            run_op(ra, rb, int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
